if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register. Feeds the decode/control stage of the 5-stage MIPS pipeline.
- Owns the PC, drives a req/ready instruction-memory port, and presents inst/pc4/valid to ID.
- Consumes ID's stall, taken-redirect (branch) and jump/jr qualifiers. On a redirect it squashes the wrong-path fetch by inserting a bubble.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous reset, active low
- stall  in  1  ID load-use stall; hold PC and IF/ID
- branch  in  1  ID redirect taken (beq/bne taken, j, jal, jr); already zero when stall=1
- jump  in  1  redirect is j/jal
- jr  in  1  redirect is jr
- br_target  in  32  beq/bne target from ID
- jr_target  in  32  forwarded rs value from ID
- j_index  in  26  instr[25:0] from ID
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address, word aligned
- imem_rdata  in  32  instruction, valid when imem_req && imem_ready
- imem_ready  in  1  fetch completes this cycle; may be combinational
- id_inst  out  32  IF/ID instruction
- id_pc4  out  32  IF/ID PC+4
- id_valid  out  1  IF/ID holds a real instruction

Behaviour:
- Reset: all registers update only on the rising clk edge while rst_n=0.
  - pc=RESET_PC, state=RUN, id_inst=0, id_pc4=0, id_valid=0, redir_pc=0.
  - imem_req=0 while rst_n=0. A reset mid-DROP abandons the drop; the in-flight response is ignored.
- Target mux, priority jr > jump > branch-compare:
  - jr=1: target = jr_target.
  - jump=1: target = {id_pc4[31:28], j_index, 2'b00}.
  - otherwise: target = br_target.
- Handshake:
  - imem_req=1 whenever not in reset.
  - imem_addr must stay stable until the cycle with imem_ready=1.
  - A transfer completes when imem_req && imem_ready.
  - With imem_ready tied to 1, throughput is 1 instr/cycle and latency is 1 cycle (fetched at PC in cycle N, visible on id_* in cycle N+1).
- FSM: RUN, DROP.
  - RUN: imem_addr=pc. Priority per cycle:
    1. stall=1: pc and IF/ID hold. Any completed fetch is discarded; the same address is re-fetched next cycle.
    2. branch=1, imem_ready=1: pc<=target; IF/ID<=bubble (inst 0, pc4 0, valid 0); stay RUN.
    3. branch=1, imem_ready=0: redir_pc<=target; IF/ID<=bubble; go to DROP.
    4. imem_ready=1: IF/ID<={imem_rdata, pc+4, 1}; pc<=pc+4.
    5. imem_ready=0: IF/ID<=bubble; pc holds.
  - DROP: imem_addr=old pc, held stable.
    - IF/ID<=bubble every cycle unless stall=1, in which case it holds.
    - A new branch=1 overwrites redir_pc (latest wins).
    - On imem_ready=1: data discarded; pc<=redir_pc, or target if branch=1 in that same cycle; go to RUN.
- Arithmetic: pc+4 wraps modulo 2^32. imem_addr[1:0] is always driven 0; target[1:0] is ignored.
- Simultaneous stall and branch cannot occur; if both are asserted, stall wins and the redirect is dropped.

Optional Feature:
- Macro IF_PERF_CNT_EN.
- When defined:
  - Adds outputs perf_fetch[31:0], counting completed fetches accepted into IF/ID.
  - Adds outputs perf_bubble[31:0], counting cycles where IF/ID loads a bubble.
  - Both counters clear on reset and wrap at 2^32.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release with imem_ready=1, imem_rdata=addr-tagged data -> imem_addr 0x0, 0x4, 0x8 on successive cycles; id_pc4 = 0x4, 0x8, 0xC; id_valid=1 from the second cycle after release.
- stall=1 for 2 cycles with pc=0x8 -> imem_addr stays 0x8, id_inst/id_pc4 unchanged; after release id_pc4 becomes 0xC.
- branch=1, br_target=0x40, imem_ready=1 -> next cycle imem_addr=0x40 and id_valid=0 for exactly one cycle, then id_pc4=0x44.
- branch=1, br_target=0x100 while imem_ready=0 at pc=0xC; ready held low 3 cycles -> imem_addr stays 0xC, id_valid=0 throughout, data dropped; the cycle after ready, imem_addr=0x100.
- jump=1, id_pc4=0x1000_0010, j_index=0x000040 -> imem_addr=0x1000_0100; then jr=1 and jump=1, jr_target=0x200 -> imem_addr=0x200.
- rst_n=0 for one cycle during DROP -> next cycle imem_addr=RESET_PC, id_valid=0, state RUN; a late imem_ready is ignored.

Source files
------------

// File: rtl/if_stage.sv
// rtl/if_stage.sv - MIPS instruction-fetch stage with IF/ID register (optional IF_PERF_CNT_EN counters)
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch,
    input  logic        jump,
    input  logic        jr,
    input  logic [31:0] br_target,
    input  logic [31:0] jr_target,
    input  logic [25:0] j_index,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc4,
`ifdef IF_PERF_CNT_EN
    output logic [31:0] perf_fetch,
    output logic [31:0] perf_bubble,
`endif
    output logic        id_valid
);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_DROP = 1'b1;

    logic [0:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_redir_pc;
    logic [31:0] r_id_inst;
    logic [31:0] r_id_pc4;
    logic        r_id_valid;

    logic        w_take;
    logic [31:0] w_target_raw;
    logic [31:0] w_target;
    logic [31:0] w_pc_plus4;

    logic [0:0]  w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_redir_nxt;
    logic [31:0] w_inst_nxt;
    logic [31:0] w_pc4_nxt;
    logic        w_valid_nxt;
    logic        w_load_fetch;
    logic        w_load_bubble;

    // A redirect coinciding with a stall is dropped: stall has priority.
    assign w_take     = branch & ~stall;
    assign w_pc_plus4 = r_pc + 32'd4;

    always_comb begin
        w_target_raw = br_target;
        if (jr) begin
            w_target_raw = jr_target;
        end else if (jump) begin
            w_target_raw = {r_id_pc4[31:28], j_index, 2'b00};
        end
    end

    assign w_target  = {w_target_raw[31:2], 2'b00};
    assign imem_req  = rst_n;
    assign imem_addr = {r_pc[31:2], 2'b00};

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_redir_nxt   = r_redir_pc;
        w_inst_nxt    = r_id_inst;
        w_pc4_nxt     = r_id_pc4;
        w_valid_nxt   = r_id_valid;
        w_load_fetch  = 1'b0;
        w_load_bubble = 1'b0;

        case (r_state)
            ST_RUN: begin
                if (stall) begin
                    w_pc_nxt = r_pc;
                end else if (w_take) begin
                    w_load_bubble = 1'b1;
                    if (imem_ready) begin
                        w_pc_nxt = w_target;
                    end else begin
                        w_redir_nxt = w_target;
                        w_state_nxt = ST_DROP;
                    end
                end else if (imem_ready) begin
                    w_load_fetch = 1'b1;
                    w_inst_nxt   = imem_rdata;
                    w_pc4_nxt    = w_pc_plus4;
                    w_valid_nxt  = 1'b1;
                    w_pc_nxt     = w_pc_plus4;
                end else begin
                    w_load_bubble = 1'b1;
                end
            end
            default: begin
                // The wrong-path fetch must finish at the old address before redirecting.
                w_load_bubble = ~stall;
                if (w_take) begin
                    w_redir_nxt = w_target;
                end
                if (imem_ready) begin
                    w_pc_nxt    = w_take ? w_target : r_redir_pc;
                    w_state_nxt = ST_RUN;
                end
            end
        endcase

        if (w_load_bubble) begin
            w_inst_nxt  = 32'd0;
            w_pc4_nxt   = 32'd0;
            w_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_RUN;
            r_pc       <= RESET_PC;
            r_redir_pc <= 32'd0;
            r_id_inst  <= 32'd0;
            r_id_pc4   <= 32'd0;
            r_id_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_redir_pc <= w_redir_nxt;
            r_id_inst  <= w_inst_nxt;
            r_id_pc4   <= w_pc4_nxt;
            r_id_valid <= w_valid_nxt;
        end
    end

    assign id_inst  = r_id_inst;
    assign id_pc4   = r_id_pc4;
    assign id_valid = r_id_valid;

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_bubble;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_perf_fetch  <= 32'd0;
            r_perf_bubble <= 32'd0;
        end else begin
            if (w_load_fetch) begin
                r_perf_fetch <= r_perf_fetch + 32'd1;
            end
            if (w_load_bubble) begin
                r_perf_bubble <= r_perf_bubble + 32'd1;
            end
        end
    end

    assign perf_fetch  = r_perf_fetch;
    assign perf_bubble = r_perf_bubble;
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage: directed table plus randomized model comparison
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        branch = 1'b0;
    logic        jump = 1'b0;
    logic        jr = 1'b0;
    logic [31:0] br_target = 32'd0;
    logic [31:0] jr_target = 32'd0;
    logic [25:0] j_index = 26'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready = 1'b0;
    logic [31:0] id_inst;
    logic [31:0] id_pc4;
    logic        id_valid;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch;
    logic [31:0] perf_bubble;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[31:16]};
    endfunction

    assign imem_rdata = memw(imem_addr);

    if_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .branch     (branch),
        .jump       (jump),
        .jr         (jr),
        .br_target  (br_target),
        .jr_target  (jr_target),
        .j_index    (j_index),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .id_inst    (id_inst),
        .id_pc4     (id_pc4),
`ifdef IF_PERF_CNT_EN
        .perf_fetch (perf_fetch),
        .perf_bubble(perf_bubble),
`endif
        .id_valid   (id_valid)
    );

    typedef struct {
        logic        rst_n, stall, branch, jump, jr, ready;
        logic [31:0] br_t, jr_t;
        logic [25:0] jidx;
        logic        exp_req;
        logic [31:0] exp_addr, exp_pc4;
        logic        exp_valid;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, s, b, j, jrr, rdy,
                                input logic [31:0] bt, jt, input logic [25:0] ji,
                                input logic [31:0] ea, ep, input logic ev);
        vec_t v;
        v.rst_n = r; v.stall = s; v.branch = b; v.jump = j; v.jr = jrr; v.ready = rdy;
        v.br_t = bt; v.jr_t = jt; v.jidx = ji;
        v.exp_req = r; v.exp_addr = ea; v.exp_pc4 = ep; v.exp_valid = ev;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, s, b, j, jrr, rdy,
                         input logic [31:0] bt, jt, input logic [25:0] ji);
        rst_n = r; stall = s; branch = b; jump = j; jr = jrr; imem_ready = rdy;
        br_target = bt; jr_target = jt; j_index = ji;
    endtask

    // Reference model state: what IF should look like after each edge.
    logic [31:0] m_pc, m_redir, m_inst, m_pc4, m_pf, m_pb;
    logic        m_drop, m_valid;

    task automatic model_step(input logic r, s, b, j, jrr, rdy,
                              input logic [31:0] bt, jt, input logic [25:0] ji);
        logic [31:0] tgt;
        logic        take;
        if (!r) begin
            m_pc = 32'd0; m_redir = 32'd0; m_drop = 1'b0;
            m_inst = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0; m_pf = 0; m_pb = 0;
            return;
        end
        tgt = jrr ? jt : (j ? {m_pc4[31:28], ji, 2'b00} : bt);
        tgt = tgt & 32'hFFFF_FFFC;
        take = b && !s;
        if (!m_drop) begin
            if (s) begin
            end else if (take) begin
                m_inst = 0; m_pc4 = 0; m_valid = 0; m_pb++;
                if (rdy) m_pc = tgt;
                else begin m_drop = 1'b1; m_redir = tgt; end
            end else if (rdy) begin
                m_inst = memw(m_pc); m_pc4 = m_pc + 4; m_valid = 1; m_pf++;
                m_pc = m_pc + 4;
            end else begin
                m_inst = 0; m_pc4 = 0; m_valid = 0; m_pb++;
            end
        end else begin
            if (!s) begin m_inst = 0; m_pc4 = 0; m_valid = 0; m_pb++; end
            if (take) m_redir = tgt;
            if (rdy) begin m_pc = m_redir; m_drop = 1'b0; end
        end
    endtask

    initial begin
        // rst stall br jump jr rdy  br_t  jr_t  jidx   exp_addr  exp_pc4  exp_valid
        tbl.push_back(mk(0,0,0,0,0,1, 32'h0,   32'h0,   26'h0,  32'h0,        32'h0,        0));
        tbl.push_back(mk(0,0,0,0,0,1, 32'h0,   32'h0,   26'h0,  32'h0,        32'h0,        0));
        tbl.push_back(mk(1,0,0,0,0,1, 32'h0,   32'h0,   26'h0,  32'h4,        32'h4,        1));
        tbl.push_back(mk(1,0,0,0,0,1, 32'h0,   32'h0,   26'h0,  32'h8,        32'h8,        1));
        tbl.push_back(mk(1,1,0,0,0,1, 32'h0,   32'h0,   26'h0,  32'h8,        32'h8,        1));
        tbl.push_back(mk(1,1,0,0,0,1, 32'h0,   32'h0,   26'h0,  32'h8,        32'h8,        1));
        tbl.push_back(mk(1,0,0,0,0,1, 32'h0,   32'h0,   26'h0,  32'hC,        32'hC,        1));
        tbl.push_back(mk(1,0,1,0,0,1, 32'h40,  32'h0,   26'h0,  32'h40,       32'h0,        0));
        tbl.push_back(mk(1,0,0,0,0,1, 32'h0,   32'h0,   26'h0,  32'h44,       32'h44,       1));
        tbl.push_back(mk(1,0,1,0,0,1, 32'hC,   32'h0,   26'h0,  32'hC,        32'h0,        0));
        tbl.push_back(mk(1,0,1,0,0,0, 32'h100, 32'h0,   26'h0,  32'hC,        32'h0,        0));
        tbl.push_back(mk(1,0,0,0,0,0, 32'h0,   32'h0,   26'h0,  32'hC,        32'h0,        0));
        tbl.push_back(mk(1,0,0,0,0,0, 32'h0,   32'h0,   26'h0,  32'hC,        32'h0,        0));
        tbl.push_back(mk(1,0,0,0,0,1, 32'h0,   32'h0,   26'h0,  32'h100,      32'h0,        0));
        tbl.push_back(mk(1,0,0,0,0,1, 32'h0,   32'h0,   26'h0,  32'h104,      32'h104,      1));
        tbl.push_back(mk(1,0,1,0,0,1, 32'h1000_000C, 32'h0, 26'h0, 32'h1000_000C, 32'h0,   0));
        tbl.push_back(mk(1,0,0,0,0,1, 32'h0,   32'h0,   26'h0,  32'h1000_0010, 32'h1000_0010, 1));
        tbl.push_back(mk(1,0,1,1,0,1, 32'h0,   32'h0,   26'h40, 32'h1000_0100, 32'h0,       0));
        tbl.push_back(mk(1,0,0,0,0,1, 32'h0,   32'h0,   26'h0,  32'h1000_0104, 32'h1000_0104, 1));
        tbl.push_back(mk(1,0,1,1,1,1, 32'h0,   32'h200, 26'h40, 32'h200,      32'h0,        0));
        tbl.push_back(mk(1,0,0,0,0,1, 32'h0,   32'h0,   26'h0,  32'h204,      32'h204,      1));
        tbl.push_back(mk(1,0,1,0,0,0, 32'h300, 32'h0,   26'h0,  32'h204,      32'h0,        0));
        tbl.push_back(mk(0,0,0,0,0,0, 32'h0,   32'h0,   26'h0,  32'h0,        32'h0,        0));
        tbl.push_back(mk(1,0,0,0,0,1, 32'h0,   32'h0,   26'h0,  32'h4,        32'h4,        1));
        tbl.push_back(mk(1,0,1,0,0,1, 32'hFFFF_FFFC, 32'h0, 26'h0, 32'hFFFF_FFFC, 32'h0,   0));
        tbl.push_back(mk(1,0,0,0,0,1, 32'h0,   32'h0,   26'h0,  32'h0,        32'h0,        1));
        tbl.push_back(mk(1,0,1,0,0,1, 32'h503, 32'h0,   26'h0,  32'h500,      32'h0,        0));
        tbl.push_back(mk(1,0,1,0,0,0, 32'h600, 32'h0,   26'h0,  32'h500,      32'h0,        0));
        tbl.push_back(mk(1,0,1,0,0,0, 32'h700, 32'h0,   26'h0,  32'h500,      32'h0,        0));
        tbl.push_back(mk(1,1,0,0,0,0, 32'h0,   32'h0,   26'h0,  32'h500,      32'h0,        0));
        tbl.push_back(mk(1,0,1,0,0,1, 32'h800, 32'h0,   26'h0,  32'h800,      32'h0,        0));
        tbl.push_back(mk(1,0,0,0,0,1, 32'h0,   32'h0,   26'h0,  32'h804,      32'h804,      1));

        foreach (tbl[i]) begin
            drive(tbl[i].rst_n, tbl[i].stall, tbl[i].branch, tbl[i].jump, tbl[i].jr,
                  tbl[i].ready, tbl[i].br_t, tbl[i].jr_t, tbl[i].jidx);
            @(posedge clk);
            #1;
            chk($sformatf("row%0d imem_req", i), {31'd0, imem_req}, {31'd0, tbl[i].exp_req});
            chk($sformatf("row%0d imem_addr", i), imem_addr, tbl[i].exp_addr);
            chk($sformatf("row%0d id_pc4", i), id_pc4, tbl[i].exp_pc4);
            chk($sformatf("row%0d id_valid", i), {31'd0, id_valid}, {31'd0, tbl[i].exp_valid});
            chk($sformatf("row%0d id_inst", i), id_inst,
                tbl[i].exp_valid ? memw(tbl[i].exp_pc4 - 32'd4) : 32'd0);
        end

        for (int c = 0; c < 600; c++) begin
            logic r, s, b, j, jrr, rdy;
            logic [31:0] bt, jt;
            logic [25:0] ji;
            r   = (c < 2) ? 1'b0 : ($urandom_range(0, 59) != 0);
            s   = ($urandom_range(0, 4) == 0);
            b   = ($urandom_range(0, 3) == 0);
            j   = $urandom_range(0, 1);
            jrr = ($urandom_range(0, 2) == 0);
            rdy = ($urandom_range(0, 2) != 0);
            bt  = $urandom;
            jt  = $urandom;
            ji  = 26'($urandom);
            drive(r, s, b, j, jrr, rdy, bt, jt, ji);
            model_step(r, s, b, j, jrr, rdy, bt, jt, ji);
            @(posedge clk);
            #1;
            chk($sformatf("rnd%0d imem_req", c), {31'd0, imem_req}, {31'd0, r});
            chk($sformatf("rnd%0d imem_addr", c), imem_addr, m_pc);
            chk($sformatf("rnd%0d id_inst", c), id_inst, m_inst);
            chk($sformatf("rnd%0d id_pc4", c), id_pc4, m_pc4);
            chk($sformatf("rnd%0d id_valid", c), {31'd0, id_valid}, {31'd0, m_valid});
`ifdef IF_PERF_CNT_EN
            chk($sformatf("rnd%0d perf_fetch", c), perf_fetch, m_pf);
            chk($sformatf("rnd%0d perf_bubble", c), perf_bubble, m_pb);
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
